// File: rtl/fetch_queue_frontend_if.sv
// fetch_queue_frontend_if: fetch control, imem port and IF/ID hand-off bundle.
// master drives control/imem data; slave is the fetch front end.
interface fetch_queue_frontend_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            PCWrite;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic [CW-1:0]   count;

  modport master (
    output PCWrite, redirect_valid, redirect_pc,
    output imem_rdata, id_ready,
    input  imem_addr, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  PCWrite, redirect_valid, redirect_pc,
    input  imem_rdata, id_ready,
    output imem_addr, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/fetch_queue_frontend.sv
// fetch_queue_frontend: PC register, FWFT fetch queue and IF/ID hand-off.
// Define FETCHQ_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_queue_frontend #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   reset,
  fetch_queue_frontend_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_e;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            q_valid;
  logic            byp;
  logic            pop;
  logic            push;
  logic            wr;
  logic            rd;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign q_valid = !empty;
  assign head_e  = mem[head];
  assign target  = fq.redirect_pc & ~XLEN'(3);

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty & fq.PCWrite & ~fq.redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign fq.id_valid = q_valid | byp;
  assign pop  = fq.id_valid & fq.id_ready & ~fq.redirect_valid;
  assign push = fq.PCWrite & ~fq.redirect_valid & (~full | pop);
  // a bypassed word taken by decode never lands in storage
  assign rd   = pop & q_valid;
  assign wr   = push & ~(byp & fq.id_ready);

  assign fq.imem_addr = pc;
  assign fq.count     = cnt;

  always_comb begin
    fq.id_pc   = '0;
    fq.id_inst = NOP;
    if (q_valid) begin
      fq.id_pc   = head_e.pc;
      fq.id_inst = head_e.inst;
    end else if (byp) begin
      fq.id_pc   = pc;
      fq.id_inst = fq.imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= RESET_PC;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (fq.redirect_valid) begin
      pc   <= target;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) pc <= pc + XLEN'(4);
      if (wr) tail <= tail + PW'(1);
      if (rd) head <= head + PW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= '{pc: pc, inst: fq.imem_rdata};
  end
endmodule
